// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs fields into R/I/S/B/U/J words behind a small output FIFO.
// Optional immediate range checking is enabled by defining RANGE_CHECK_EN.
module instr_encoder #(
  parameter  int DEPTH = 4,
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [XLEN-1:0]  imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM_LOAD = 7'b0000011;
  localparam logic [6:0] OP_J_JALR   = 7'b1100111;
  localparam logic [6:0] OP_S_TYPE   = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE   = 7'b1100011;
  localparam logic [6:0] OP_U_LUI    = 7'b0110111;
  localparam logic [6:0] OP_U_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_J_JAL    = 7'b1101111;

  logic [31:0]      w_word;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_mem [DEPTH];

  always_comb begin
    w_word = {funct7, rs2, rs1, funct3, rd, opcode};
    case (opcode)
      OP_IMM, OP_IMM_LOAD, OP_J_JALR:
        w_word = {imm[11:0], rs1, funct3, rd, opcode};
      OP_S_TYPE:
        w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      OP_B_TYPE:
        w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      OP_U_LUI, OP_U_AUIPC:
        w_word = {imm[31:12], rd, opcode};
      OP_J_JAL:
        w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: ;
    endcase
  end

  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // flush wins over any same-cycle transfer
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  // Head is gated so the outputs read zero while empty, storage itself stays unreset
  assign out_instr = out_valid ? r_mem[r_rd_ptr] : 32'h0;

`ifdef RANGE_CHECK_EN
  logic            w_err;
  logic            r_err_mem [DEPTH];
  logic [XLEN-1:0] w_sext12;
  logic [XLEN-1:0] w_sext13;
  logic [XLEN-1:0] w_sext21;

  assign w_sext12 = {{(XLEN-12){imm[11]}}, imm[11:0]};
  assign w_sext13 = {{(XLEN-13){imm[12]}}, imm[12:0]};
  assign w_sext21 = {{(XLEN-21){imm[20]}}, imm[20:0]};

  always_comb begin
    w_err = 1'b0;
    case (opcode)
      OP_IMM, OP_IMM_LOAD, OP_J_JALR, OP_S_TYPE: w_err = (imm != w_sext12);
      OP_B_TYPE:            w_err = (imm != w_sext13) || imm[0];
      OP_J_JAL:             w_err = (imm != w_sext21) || imm[0];
      OP_U_LUI, OP_U_AUIPC: w_err = (imm[11:0] != 12'h0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_err_mem[r_wr_ptr] <= w_err;
  end

  assign out_err = out_valid ? r_err_mem[r_rd_ptr] : 1'b0;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;
  logic [32:0] q[$];

  instr_encoder #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .count(count)
  );

  always #5 clk = ~clk;

  // Reference encoding built with shifts/masks on the architectural field positions
  function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] d,
                                            input logic [4:0] s1, input logic [4:0] s2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] im);
    logic [31:0] w;
    logic [31:0] base_rs;
    logic e;
    int si;
    si = im;
    e = 1'b0;
    base_rs = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    case (op)
      7'h13, 7'h03, 7'h67: begin
        w = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
        e = (si < -2048) || (si > 2047);
      end
      7'h23: begin
        w = (((im >> 5) & 32'h7F) << 25) | base_rs | ((im & 32'h1F) << 7);
        e = (si < -2048) || (si > 2047);
      end
      7'h63: begin
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | base_rs
          | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
        e = (si < -4096) || (si > 4095) || (si % 2 != 0);
      end
      7'h37, 7'h17: begin
        w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
        e = (im % 4096) != 0;
      end
      7'h6F: begin
        w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
          | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
        e = (si < -1048576) || (si > 1048575) || (si % 2 != 0);
      end
      default: w = (32'(f7) << 25) | base_rs | (32'(d) << 7);
    endcase
`ifndef RANGE_CHECK_EN
    e = 1'b0;
`endif
    return {e, w};
  endfunction

  task automatic set_req(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic rand_req();
    logic [6:0] ops [9];
    logic [31:0] im;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    case ($urandom_range(0, 3))
      0: im = 32'($signed($urandom_range(0, 4095)) - 2048);
      1: im = 32'($urandom_range(0, 2097151) & 32'hFFFFFFFE) - 32'h100000;
      2: im = $urandom() & 32'hFFFFF000;
      default: im = $urandom();
    endcase
    if ($urandom_range(0, 4) == 0) opcode = 7'($urandom());
    else opcode = ops[$urandom_range(0, 8)];
    set_req(opcode, 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
            7'($urandom()), im);
  endtask

  // Advance one clock edge and mirror its effect on the reference queue
  task automatic cycle();
    bit push, pop;
    logic [32:0] ent;
    push = in_valid && (q.size() != DEPTH);
    pop  = out_ready && (q.size() != 0);
    ent  = model_enc(opcode, rd, rs1, rs2, funct3, funct7, imm);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ent);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #12;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d out_valid=%b out_instr=%h out_err=%b, need 0/0/0/0",
               count, out_valid, out_instr, out_err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
  endtask

  typedef struct {
    logic [6:0] op; logic [4:0] d; logic [4:0] s1; logic [4:0] s2;
    logic [2:0] f3; logic [31:0] im; logic [31:0] word; logic err;
  } vec_t;

  task automatic test_vectors();
    vec_t v [6];
    logic big_err;
`ifdef RANGE_CHECK_EN
    big_err = 1'b1;
`else
    big_err = 1'b0;
`endif
    v[0] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5,        32'h00500093, 1'b0};
    v[1] = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8,        32'h0020A423, 1'b0};
    v[2] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    v[3] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800, 32'h001000EF, 1'b0};
    v[4] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 1'b0};
    v[5] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,     32'h80000093, big_err};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(v[i].op, v[i].d, v[i].s1, v[i].s2, v[i].f3, 7'h7F, v[i].im);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== v[i].word || out_err !== v[i].err) begin
        errors++;
        $display("FAIL vector_%0d: valid=%b instr=%h err=%b, need 1 %h %b",
                 i, out_valid, out_instr, out_err, v[i].word, v[i].err);
      end
      cycle();
    end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_req();
      cycle();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== CNT_W'(4) || in_ready !== 1'b0 || q.size() != 4) begin
      errors++;
      $display("FAIL fill_full: count=%0d in_ready=%b, need 4 0", count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_err, out_instr} !== q[0]) begin
        errors++;
        $display("FAIL drain_%0d: valid=%b got %h need %h", i, out_valid, {out_err, out_instr}, q[0]);
      end
      cycle();
    end
    checks++;
    if (out_valid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b count=%0d need 0 0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_req();
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_req();
      cycle();
      checks++;
      if (count !== CNT_W'(q.size()) || (q.size() != 0 && {out_err, out_instr} !== q[0])) begin
        errors++;
        $display("FAIL b2b_%0d: count=%0d head=%h need %0d %h",
                 i, count, {out_err, out_instr}, q.size(), q.size() != 0 ? q[0] : 33'h0);
      end
    end
    checks++;
    if (count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL b2b_steady: count=%0d need 3", count);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_req();
      cycle();
    end
    out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b in_ready=%b need 0 0 1", count, out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_req();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
      flush = 1'b0;
      checks++;
      if (count !== CNT_W'(q.size()) || out_valid !== (q.size() != 0)
          || in_ready !== (q.size() != DEPTH)
          || (q.size() != 0 && {out_err, out_instr} !== q[0])) begin
        errors++;
        $display("FAIL random_%0d: count=%0d valid=%b rdy=%b head=%h need %0d %h",
                 i, count, out_valid, in_ready, {out_err, out_instr}, q.size(),
                 q.size() != 0 ? q[0] : 33'h0);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_req();
      cycle();
    end
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d valid=%b instr=%h err=%b need 0 0 0 0",
               count, out_valid, out_instr, out_err);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL async_release: in_ready=%b count=%0d need 1 0", in_ready, count);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
